// File: rtl/dwc_sched.sv
// Duplicate-with-compare scheduler: pairs one result from each core, issues a compare, retries or faults.
// Optional DWC_SCHED_ERR_COUNT_EN adds err_total, a saturating mismatch+timeout counter.
module dwc_sched #(
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 1024,
    localparam int unsigned RCW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           a_valid,
    input  logic [DW-1:0]  a_data,
    output logic           a_ack,
    input  logic           b_valid,
    input  logic [DW-1:0]  b_data,
    output logic           b_ack,
    output logic           cmp_start,
    output logic [DW-1:0]  cmp_a,
    output logic [DW-1:0]  cmp_b,
    input  logic           cmp_done,
    input  logic           cmp_match,
    output logic           result_ok,
    output logic           retry_req,
    output logic           timeout,
    output logic           fault,
    output logic           irq,
    input  logic           fault_clr,
    output logic [RCW-1:0] retry_cnt
`ifdef DWC_SCHED_ERR_COUNT_EN
    ,
    output logic [15:0]    err_total
`endif
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_COMPARE,
        S_WAIT_CMP,
        S_RETRY,
        S_FAULT
    } state_e;

    state_e         state_q;
    logic           a_got_q, b_got_q;
    logic [TW-1:0]  timer_q;
    logic [RCW-1:0] retry_cnt_q;
    logic [DW-1:0]  cmp_a_q, cmp_b_q;
    logic           a_ack_q, b_ack_q, cmp_start_q;
    logic           result_ok_q, retry_req_q, timeout_q, fault_q;
`ifdef DWC_SCHED_ERR_COUNT_EN
    logic [15:0]    err_q;
`endif

    logic a_take, b_take, one_got, tmo_hit, mismatch;

    // A second capture on the expiry edge wins over the timeout.
    assign a_take   = (state_q == S_COLLECT) && a_valid && !a_got_q;
    assign b_take   = (state_q == S_COLLECT) && b_valid && !b_got_q;
    assign one_got  = a_got_q ^ b_got_q;
    assign tmo_hit  = (state_q == S_COLLECT) && one_got && !a_take && !b_take
                      && (timer_q == TW'(TIMEOUT - 1));
    assign mismatch = tmo_hit || ((state_q == S_WAIT_CMP) && cmp_done && !cmp_match);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_COLLECT;
            a_got_q     <= 1'b0;
            b_got_q     <= 1'b0;
            timer_q     <= '0;
            retry_cnt_q <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            cmp_start_q <= 1'b0;
            result_ok_q <= 1'b0;
            retry_req_q <= 1'b0;
            timeout_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            cmp_start_q <= 1'b0;
            result_ok_q <= 1'b0;
            retry_req_q <= 1'b0;
            timeout_q   <= tmo_hit;

            case (state_q)
                S_COLLECT: begin
                    if (a_got_q && b_got_q) begin
                        state_q     <= S_COMPARE;
                        cmp_start_q <= 1'b1;
                    end else begin
                        if (a_take) begin
                            cmp_a_q <= a_data;
                            a_got_q <= 1'b1;
                            a_ack_q <= 1'b1;
                        end
                        if (b_take) begin
                            cmp_b_q <= b_data;
                            b_got_q <= 1'b1;
                            b_ack_q <= 1'b1;
                        end
                        // Timer idles at 0 until the first capture, then runs while only one is held.
                        if (!a_got_q && !b_got_q) begin
                            timer_q <= '0;
                        end else if (one_got) begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                S_COMPARE: begin
                    state_q <= S_WAIT_CMP;
                end
                S_WAIT_CMP: begin
                    if (cmp_done && cmp_match) begin
                        result_ok_q <= 1'b1;
                        retry_cnt_q <= '0;
                        a_got_q     <= 1'b0;
                        b_got_q     <= 1'b0;
                        state_q     <= S_COLLECT;
                    end
                end
                S_RETRY: begin
                    retry_req_q <= 1'b1;
                    a_got_q     <= 1'b0;
                    b_got_q     <= 1'b0;
                    timer_q     <= '0;
                    state_q     <= S_COLLECT;
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        fault_q     <= 1'b0;
                        retry_cnt_q <= '0;
                        a_got_q     <= 1'b0;
                        b_got_q     <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= S_COLLECT;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase

            // Shared mismatch/timeout path overrides the per-state next state.
            if (mismatch) begin
                if (retry_cnt_q < RCW'(MAX_RETRY)) begin
                    state_q     <= S_RETRY;
                    retry_cnt_q <= retry_cnt_q + RCW'(1);
                end else begin
                    state_q <= S_FAULT;
                    fault_q <= 1'b1;
                end
            end
        end
    end

`ifdef DWC_SCHED_ERR_COUNT_EN
    // Saturating lifetime error count; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else if (mismatch && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_total = err_q;
`endif

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign cmp_start = cmp_start_q;
    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign result_ok = result_ok_q;
    assign retry_req = retry_req_q;
    assign timeout   = timeout_q;
    assign fault     = fault_q;
    assign irq       = fault_q;
    assign retry_cnt = retry_cnt_q;

endmodule

// File: doc/dwc_sched.md
Name: dwc_sched

Overview:
- Scheduler for the duplicate-with-compare datapath in the dual-MicroBlaze fault-tolerant system.
- Collects one result word from each core over independent valid/ack handshakes and issues a single compare to the comparator.
- On mismatch or timeout, requests re-execution up to MAX_RETRY times, then declares a sticky fault and interrupts the supervisor.

Parameters:
- DW, 32, result word width.
- MAX_RETRY, 3, re-execution attempts allowed before fault (0 = fault on first mismatch).
- TIMEOUT, 1024, cycles allowed between first and second capture.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  core A result present.
- a_data  in  DW  core A result.
- a_ack  out  1  one-cycle capture acknowledge to core A.
- b_valid  in  1  core B result present.
- b_data  in  DW  core B result.
- b_ack  out  1  one-cycle capture acknowledge to core B.
- cmp_start  out  1  one-cycle compare request.
- cmp_a  out  DW  latched A operand, held stable from cmp_start until cmp_done.
- cmp_b  out  DW  latched B operand, same hold rule.
- cmp_done  in  1  comparator result valid, one-cycle pulse.
- cmp_match  in  1  compare result, sampled only when cmp_done=1.
- result_ok  out  1  one-cycle pulse on a matched compare.
- retry_req  out  1  one-cycle pulse requesting both cores re-execute.
- timeout  out  1  one-cycle pulse when the second capture times out.
- fault  out  1  sticky fault flag.
- irq  out  1  interrupt; equals fault.
- fault_clr  in  1  supervisor clears fault.
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries used in the current transaction.

Behaviour:
- Reset (async, active-high): state=COLLECT; every output=0; captured flags cleared; timer=0; retry_cnt=0; cmp_a/cmp_b=0.
- All outputs are registered.
- States: COLLECT, COMPARE, WAIT_CMP, RETRY, FAULT.
- COLLECT, capture:
  - At a clock edge with a_valid=1 and A not yet captured: latch a_data, set a_got, drive a_ack=1 for the next cycle only.
  - B is handled identically and independently; both may capture on the same edge.
  - While a core's got flag is set, its valid is ignored and no further ack is issued.
- COLLECT, timer:
  - Starts at 0 on the first capture and increments each cycle while exactly one core is captured.
  - Reaching TIMEOUT-1 without the second capture: pulse timeout, then take the mismatch path below.
- COLLECT, exit: when both got flags are set, go to COMPARE. The cycle after the second capture has cmp_start=1 (1-cycle latency from second capture).
- COMPARE: cmp_start=1 for exactly one cycle, then WAIT_CMP.
- WAIT_CMP:
  - Holds cmp_a/cmp_b; no timeout.
  - cmp_done with cmp_match=1: pulse result_ok; clear retry_cnt and got flags; go to COLLECT.
  - cmp_done with cmp_match=0: mismatch path.
- Mismatch path:
  - retry_cnt<MAX_RETRY: go to RETRY; retry_cnt increments.
  - retry_cnt==MAX_RETRY: go to FAULT.
- RETRY: retry_req=1 for one cycle; clear got flags and timer; go to COLLECT.
- FAULT:
  - fault=1 and irq=1 held; a_ack/b_ack stay 0; valids ignored.
  - fault_clr=1: fault/irq drop next cycle; retry_cnt=0; got flags cleared; go to COLLECT.
  - fault_clr outside FAULT is ignored.
- Simultaneous events:
  - cmp_done in any state other than WAIT_CMP is ignored.
  - A timeout edge coinciding with the second capture counts as a capture; no timeout.
- Reset mid-transaction discards captured data; no pulse outputs are generated by reset.
- retry_cnt never exceeds MAX_RETRY.

Optional Feature:
- Macro: DWC_SCHED_ERR_COUNT_EN.
- Defined:
  - Adds output err_total [15:0], a saturating count of mismatches plus timeouts since reset. Saturates at 16'hFFFF.
  - Not cleared by fault_clr; reset value 0.
  - Increments on the same cycle the mismatch path is taken.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Match: A=32'h1234_5678, then B=32'h1234_5678 two cycles later.
  - a_ack and b_ack one cycle each; cmp_start one cycle after B capture; cmp_a=cmp_b=32'h1234_5678.
  - cmp_done/match=1 gives result_ok pulse and retry_cnt=0.
- Simultaneous: both valids in the same cycle with A=5, B=5.
  - Both acks in the same cycle; single cmp_start; no duplicate ack while valids stay high.
- Mismatch recovery: A=1, B=2, comparator mismatch.
  - retry_req pulse; retry_cnt=1.
  - Re-submit A=B=7 with match: result_ok; retry_cnt=0.
- Fault after retries (MAX_RETRY=3): four consecutive mismatches.
  - Three retry_req pulses, then fault=irq=1 with retry_cnt=3.
  - Valids receive no ack; fault_clr returns to COLLECT with fault=0.
- Timeout (TIMEOUT=16): only a_valid is asserted.
  - timeout pulse 16 cycles after A capture, followed by retry_req; retry_cnt=1.
- Async reset: assert reset in WAIT_CMP mid-cycle.
  - All outputs 0 immediately, without waiting for a clock edge.
  - A late cmp_done after reset is ignored.
  - With DWC_SCHED_ERR_COUNT_EN: err_total=0 after reset and increments by 1 per mismatch.
